// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests, buffers returned
// words in a 2-entry queue and hands them to decode; downstream redirects squash wrong-path work.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [6:0]  id_opcode_o,
  output logic [2:0]  id_funct3_o,
  output logic [6:0]  id_funct7_o
);

  localparam int unsigned QDEPTH = 2;
  localparam logic [31:0] Nop    = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  drop_q, drop_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        head_q, head_d, tail_q, tail_d;
  logic        ifw_q, ifw_d, ifr_q, ifr_d;
  logic [31:0] qpc_q [QDEPTH];
  logic [31:0] qins_q [QDEPTH];
  logic [31:0] ifpc_q [QDEPTH];

  logic grant, push, pop;
  logic unused_rpc;

  assign unused_rpc = ^redirect_pc_i[1:0];

  // Credits cover both in-flight requests and queued words, so the queue never overflows.
  assign imem_req_o  = rst_ni & ~redirect_valid_i &
                       (({1'b0, out_q} + {1'b0, cnt_q}) < 3'(QDEPTH));
  assign imem_addr_o = pc_q;
  assign id_valid_o  = (cnt_q != 2'd0) & ~redirect_valid_i;

  assign grant = imem_req_o & imem_gnt_i;
  assign pop   = id_valid_o & id_ready_i;
  assign push  = imem_rvalid_i & (drop_q == 2'd0) & ~redirect_valid_i;

  assign id_instr_o  = (cnt_q != 2'd0) ? qins_q[head_q] : Nop;
  assign id_pc_o     = (cnt_q != 2'd0) ? qpc_q[head_q] : 32'h0;
  assign id_opcode_o = id_instr_o[6:0];
  assign id_funct3_o = id_instr_o[14:12];
  assign id_funct7_o = id_instr_o[31:25];

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    // The in-flight PC FIFO tracks every request, including ones whose data gets dropped.
    ifw_d  = ifw_q ^ grant;
    ifr_d  = ifr_q ^ imem_rvalid_i;
    if (redirect_valid_i) begin
      pc_d   = {redirect_pc_i[31:2], 2'b00};
      out_d  = out_q - {1'b0, imem_rvalid_i};
      drop_d = out_q - {1'b0, imem_rvalid_i};
      cnt_d  = 2'd0;
      head_d = tail_q;
    end else begin
      if (grant) pc_d = pc_q + 32'd4;
      out_d = out_q + {1'b0, grant} - {1'b0, imem_rvalid_i};
      if (imem_rvalid_i && drop_q != 2'd0) drop_d = drop_q - 2'd1;
      if (push) tail_d = ~tail_q;
      if (pop)  head_d = ~head_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q   <= RESET_PC;
      out_q  <= 2'd0;
      drop_q <= 2'd0;
      cnt_q  <= 2'd0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      ifw_q  <= 1'b0;
      ifr_q  <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        qpc_q[i]  <= 32'h0;
        qins_q[i] <= Nop;
        ifpc_q[i] <= 32'h0;
      end
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      ifw_q  <= ifw_d;
      ifr_q  <= ifr_d;
      if (grant) ifpc_q[ifw_q] <= pc_q;
      if (push) begin
        qpc_q[tail_q]  <= ifpc_q[ifr_q];
        qins_q[tail_q] <= imem_rdata_i;
      end
    end
  end

endmodule
